// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch, data) for one single-port variable-latency memory.
// Data has priority; fetch wins once data has taken MAX_D_STREAK grants in a row past it.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned TMO_W    = 8;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state;
  logic                owner_d;
  logic [STREAK_W-1:0] streak;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                pick_d_c;

  // Data wins unless fetch is waiting and data already used up its streak.
  assign pick_d_c = d_req && !(i_req && (streak == STREAK_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner_d  <= 1'b0;
      streak   <= '0;
      tmo_cnt  <= '0;
      i_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_gnt    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state <= REQ;
            busy  <= 1'b1;
            m_req <= 1'b1;
            if (pick_d_c) begin
              owner_d <= 1'b1;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_wstrb <= d_wstrb;
              if (!i_req)                    streak <= '0;
              else if (streak != STREAK_MAX) streak <= streak + STREAK_W'(1);
            end else begin
              owner_d <= 1'b0;
              m_we    <= 1'b0;
              m_addr  <= i_addr;
              m_wdata <= '0;
              m_wstrb <= '0;
              streak  <= '0;
            end
          end
        end
        REQ: begin
          if (m_ready) begin
            m_req   <= 1'b0;
            tmo_cnt <= '0;
            state   <= RESP;
            if (owner_d) d_gnt <= 1'b1;
            else         i_gnt <= 1'b1;
          end
        end
        RESP: begin
          if (m_rvalid) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= m_we ? '0 : m_rdata;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= m_rdata;
            end
          end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
            // Abort: hand the owner a zero response flagged as an error.
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= '0;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised + directed bench for mem_port_arbiter against a transaction-level model
// with timestamped accept/response deadlines.
module tb_mem_port_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned TMO  = 8;

  typedef logic [68:0] val_t;

  logic        clk, reset;
  logic        i_req, d_req, d_we, m_ready, m_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wstrb;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, err, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction model: one outstanding access, owner chosen by the priority rule.
  bit   act, acc, own_d;
  val_t cmd_exp;
  int   acc_e, streak, edge_n;
  // Memory agent and stimulus knobs.
  bit   prev_mreq, mem_pend, mem_drop, rdata_rand;
  int   mem_cnt, mem_lat, stray_pct;
  // Grant order log (1 = fetch).
  bit       log_on;
  int       n_log;
  bit [9:0] seq;

  task automatic check(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic cycle();
    bit e_ig, e_dg, e_ir, e_dr, e_err, e_mreq, acc_now;
    logic [31:0] e_rdata;
    @(posedge clk);
    #1;
    edge_n++;
    {e_ig, e_dg, e_ir, e_dr, e_err} = '0;
    e_rdata = '0;
    acc_now = prev_mreq && m_ready;
    if (!act) begin
      if (i_req || d_req) begin
        own_d = d_req && !(i_req && streak == MAXS);
        if (own_d) begin
          cmd_exp = {d_we, d_addr, d_wdata, d_wstrb};
          streak  = i_req ? ((streak < MAXS) ? streak + 1 : streak) : 0;
        end else begin
          cmd_exp = {1'b0, i_addr, 32'h0, 4'h0};
          streak  = 0;
        end
        act = 1'b1;
        acc = 1'b0;
      end
    end else if (!acc) begin
      if (m_ready) begin
        acc   = 1'b1;
        acc_e = edge_n;
        if (own_d) e_dg = 1'b1; else e_ig = 1'b1;
      end
    end else if (m_rvalid || (TMO != 0 && edge_n == acc_e + int'(TMO))) begin
      e_err   = !m_rvalid;
      e_rdata = (m_rvalid && !(own_d && cmd_exp[68])) ? m_rdata : 32'h0;
      if (own_d) e_dr = 1'b1; else e_ir = 1'b1;
      act = 1'b0;
    end
    e_mreq = act && !acc;

    check("m_req",    val_t'(m_req),    val_t'(e_mreq));
    check("busy",     val_t'(busy),     val_t'(act));
    check("i_gnt",    val_t'(i_gnt),    val_t'(e_ig));
    check("d_gnt",    val_t'(d_gnt),    val_t'(e_dg));
    check("i_rvalid", val_t'(i_rvalid), val_t'(e_ir));
    check("d_rvalid", val_t'(d_rvalid), val_t'(e_dr));
    check("err",      val_t'(err),      val_t'(e_err));
    if (e_mreq) check("m_cmd", val_t'({m_we, m_addr, m_wdata, m_wstrb}), cmd_exp);
    if (e_ir)   check("i_rdata", val_t'(i_rdata), val_t'(e_rdata));
    if (e_dr)   check("d_rdata", val_t'(d_rdata), val_t'(e_rdata));

    if (log_on && (i_gnt || d_gnt) && n_log < 10) begin
      seq[n_log] = i_gnt;
      n_log++;
    end

    // Memory side: one response per accepted request after a delay, or dropped.
    m_rvalid = 1'b0;
    if (acc_now && !mem_drop) begin
      mem_pend = 1'b1;
      mem_cnt  = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 3));
    end
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        m_rvalid = 1'b1;
        mem_pend = 1'b0;
      end else mem_cnt--;
    end else if (stray_pct > 0 && int'($urandom_range(0, 99)) < stray_pct) m_rvalid = 1'b1;
    prev_mreq = m_req;
    if (rdata_rand) m_rdata = $urandom;
  endtask

  task automatic drain();
    i_req = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 40 && act; k++) cycle();
    check("drain", val_t'(act), val_t'(0));
    cycle();
  endtask

  task automatic run_log(input int n, input bit hold);
    n_log  = 0;
    seq    = '0;
    log_on = 1'b1;
    for (int k = 0; k < 40 * n && n_log < n; k++) begin
      cycle();
      if (!hold) begin
        if (i_gnt) i_req = 1'b0;
        if (d_gnt) d_req = 1'b0;
      end
    end
    check("grant_count", val_t'(n_log), val_t'(n));
    log_on = 1'b0;
    drain();
  endtask

  initial begin
    int g, r;
    reset = 1'b0;
    {i_req, d_req, d_we, m_ready, m_rvalid} = '0;
    {i_addr, d_addr, d_wdata, d_wstrb, m_rdata} = '0;
    {act, acc, own_d, prev_mreq, mem_pend, mem_drop, rdata_rand, log_on} = '0;
    cmd_exp = '0; acc_e = 0; streak = 0; edge_n = 0; mem_cnt = 0; mem_lat = 0;
    stray_pct = 0; n_log = 0; seq = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", val_t'({m_req, m_we, m_addr, m_wstrb, i_gnt, d_gnt, i_rvalid, d_rvalid, err, busy}), val_t'(0));
    reset = 1'b1;

    // Fetch only, zero-wait memory.
    m_rdata = 32'h0050_0093;
    m_ready = 1'b1;
    i_req = 1'b1; i_addr = 32'h100;
    cycle();
    check("f_maddr", val_t'(m_addr), val_t'(32'h100));
    cycle();
    check("f_gnt", val_t'(i_gnt), val_t'(1));
    i_req = 1'b0;
    cycle();
    check("f_rdata", val_t'({i_rvalid, i_rdata}), val_t'({1'b1, 32'h0050_0093}));
    check("f_dside", val_t'({d_gnt, d_rvalid, d_rdata}), val_t'(0));

    // Store with three cycles of memory back-pressure.
    m_ready = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'hF;
    repeat (3) cycle();
    check("s_held", val_t'({m_req, m_we, m_addr, m_wdata, m_wstrb}),
          val_t'({1'b1, 1'b1, 32'h2000, 32'hCAFE_F00D, 4'hF}));
    m_ready = 1'b1;
    cycle();
    check("s_gnt", val_t'(d_gnt), val_t'(1));
    d_req = 1'b0;
    cycle();
    check("s_rdata", val_t'({d_rvalid, d_rdata}), val_t'({1'b1, 32'h0}));
    cycle();

    // Simultaneous single requests: data then fetch.
    d_we = 1'b0; d_addr = 32'h3000;
    i_req = 1'b1; i_addr = 32'h204; d_req = 1'b1;
    run_log(2, 1'b0);
    check("simul_order", val_t'(seq[1:0]), val_t'(2'b10));

    // Both held continuously: four data grants then one fetch.
    mem_lat = -1;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h400; d_addr = 32'h500;
    run_log(10, 1'b1);
    check("streak_seq", val_t'(seq), val_t'(10'b10_0001_0000));

    // Timeout on a dropped load, then a late response in IDLE.
    mem_drop = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    g = 0; r = 0;
    for (int k = 0; k < 10 && !d_gnt; k++) cycle();
    g = edge_n;
    d_req = 1'b0;
    for (int k = 0; k < 30 && !d_rvalid; k++) cycle();
    r = edge_n;
    check("tmo_lat", val_t'(r - g), val_t'(TMO));
    check("tmo_resp", val_t'({d_rvalid, d_rdata, err}), val_t'({1'b1, 32'h0, 1'b1}));
    mem_drop = 1'b0;
    stray_pct = 100;
    cycle();
    stray_pct = 0;
    cycle();
    check("late_rv", val_t'({i_rvalid, d_rvalid, busy}), val_t'(0));

    // Asynchronous reset while waiting in REQ.
    m_ready = 1'b0;
    i_req = 1'b1; i_addr = 32'h340;
    repeat (2) cycle();
    #2;
    reset = 1'b0;
    #1;
    check("rst_async", val_t'({m_req, busy, i_gnt, d_gnt, i_rvalid, d_rvalid, err}), val_t'(0));
    {act, acc, mem_pend, prev_mreq} = '0;
    streak = 0;
    i_req = 1'b0; m_rvalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_ready = 1'b1; mem_lat = 0;
    i_req = 1'b1; i_addr = 32'h380;
    cycle();
    cycle();
    check("rst_gnt", val_t'(i_gnt), val_t'(1));
    i_req = 1'b0;
    cycle();
    check("rst_rvalid", val_t'(i_rvalid), val_t'(1));

    // Random traffic.
    mem_lat = -1; rdata_rand = 1'b1; stray_pct = 3;
    for (int k = 0; k < 1500; k++) begin
      mem_drop = ($urandom_range(0, 15) == 0);
      cycle();
      if (i_req && i_gnt) i_req = 1'b0;
      if (d_req && d_gnt) d_req = 1'b0;
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom;
        d_wdata = $urandom;
        d_wstrb = 4'($urandom_range(0, 15));
      end
      m_ready = ($urandom_range(0, 2) != 0);
    end
    stray_pct = 0;
    mem_drop = 1'b0;
    m_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the pipeline's instruction-fetch requester and data (load/store) requester.
- Serialises accesses using a req/ready/rvalid handshake, with data-side priority and an anti-starvation limit for fetch.
- Routes each response back to the requester that issued it, and flags response timeouts.
- Sits between the core's fetch/memory stages and the shared RAM/bus.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive data grants while fetch is waiting; the next grant then goes to fetch (range 1..15).
- TIMEOUT, 64: cycles to wait in RESP for m_rvalid before aborting; 0 disables the timeout (range 0..255).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  32  fetch address
- i_gnt  out  1  one-cycle pulse: fetch request accepted by memory
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  32  fetched instruction
- d_req  in  1  data request; held with d_we, d_addr, d_wdata, d_wstrb until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  byte enables
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged
- d_rdata  out  32  load data (0 for stores)
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_wstrb  out  4  memory byte enables
- m_ready  in  1  memory accepts the request in any cycle where m_req && m_ready
- m_rvalid  in  1  memory response; exactly one per accepted request, including writes
- m_rdata  in  32  memory read data
- err  out  1  one-cycle pulse alongside the rvalid of a timed-out transaction
- busy  out  1  1 whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset low (asynchronous): state = IDLE; every output = 0; streak counter = 0; timeout counter = 0; owner = fetch. Any transaction in flight is abandoned, m_req drops immediately.
- FSM states:
  - IDLE
    - No request: stay in IDLE.
    - d_req && !(i_req && streak == MAX_D_STREAK): owner = data.
    - Else if i_req: owner = fetch.
    - On selecting an owner: latch that owner's command into the m_* registers, set m_req = 1 (m_we = 0 and m_wstrb = 0 for fetch), go to REQ.
  - REQ
    - Hold m_* stable while !m_ready.
    - On m_ready: m_req <= 0, pulse the owner's gnt in the next cycle, clear the timeout counter, go to RESP.
  - RESP
    - On m_rvalid: owner's rvalid <= 1 and owner's rdata <= m_rdata (d_rdata <= 0 if the access was a store), go to IDLE.
    - If TIMEOUT != 0 and the timeout counter reaches TIMEOUT-1 without m_rvalid: owner's rvalid <= 1, rdata <= 0, err <= 1, go to IDLE.
- Latency with zero memory wait: req sampled at edge 0; m_req high after edge 0; gnt high after edge 1; m_rvalid in that same cycle gives rvalid high after edge 2. Minimum issue interval is 3 cycles per transaction.
- Streak counter is updated at each IDLE arbitration:
  - Data grant with i_req high: increment, saturating at MAX_D_STREAK.
  - Fetch grant, or i_req low: clear to 0.
- The requester that is not selected keeps its req asserted. The arbiter does not resample requests outside IDLE.
- Simultaneous i_req and d_req with streak < MAX_D_STREAK: data wins.
- m_rvalid seen in IDLE or REQ is a stale/late response: ignore it, produce no rvalid pulse.
- m_ready in IDLE or RESP: ignore it.
- There is no timeout in REQ; m_req stays asserted indefinitely.
- Request inputs are not checked for stability. Changing them before gnt is a requester protocol violation, and the latched values are used.

Test Plan:
- Fetch only, m_ready = 1, m_rvalid 1 cycle after acceptance, i_addr = 0x100, m_rdata = 0x00500093 -> m_addr = 0x100 after edge 0; i_gnt after edge 1; i_rvalid with i_rdata = 0x00500093 after edge 2; d_* outputs stay 0.
- Store, d_addr = 0x2000, d_wdata = 0xCAFEF00D, d_wstrb = 0xF, m_ready delayed 3 cycles -> m_* held stable for 3 cycles; d_gnt pulses once; d_rvalid with d_rdata = 0.
- i_req and d_req held high continuously, MAX_D_STREAK = 4 -> grant order D, D, D, D, I, D, D, D, D, I; never 5 consecutive D grants.
- TIMEOUT = 8, m_rvalid never asserted on a load -> d_rvalid = 1, d_rdata = 0, err = 1, all 8 cycles after entering RESP; a late m_rvalid arriving while in IDLE produces no rvalid.
- Reset asserted while in REQ with m_req = 1 -> m_req, busy and all gnt/rvalid go to 0 without a clock edge; after release, the first request follows the normal latency.
- Simultaneous single requests with streak 0 -> data granted first; fetch granted on the next IDLE arbitration, with i_addr still held.
